// File: rtl/reservoir_flow_ctrl.sv
// reservoir_flow_ctrl: N-sensor reservoir level tracker driving nominal and supplemental flow valves.
// Optional input debounce filter enabled by defining RFC_DEBOUNCE_EN.
module reservoir_flow_ctrl #(
   parameter int N_LEVELS        = 3,
   parameter int LW              = $clog2(N_LEVELS + 1),
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_LEVELS-1:0] s,
   output logic [N_LEVELS-1:0] fr,
   output logic                dfr,
   output logic [LW-1:0]       level,
   output logic                sensor_fault,
   output logic                fault_sticky
);
   logic [N_LEVELS-1:0] sv;
   logic [LW-1:0]       m;
   logic                valid;
   logic                down;
`ifdef RFC_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [N_LEVELS-1:0] s_q;
   logic [CW-1:0]       cnt;
   // sv only follows s after it has matched its registered copy for DEBOUNCE_CYCLES edges
   always_ff @(posedge clk) begin
      if (reset) begin
         s_q <= '0;
         cnt <= '0;
         sv  <= '0;
      end else begin
         s_q <= s;
         if (s != s_q) cnt <= '0;
         else if (cnt != CW'(DEBOUNCE_CYCLES - 1)) cnt <= cnt + 1'b1;
         if (s == s_q && cnt == CW'(DEBOUNCE_CYCLES - 1)) sv <= s_q;
      end
   end
`else
   assign sv = s;
`endif
   // a thermometer code plus one is a power of two, so it shares no set bit with itself
   assign valid = (sv & (sv + 1'b1)) == '0;
   always_comb begin
      m = '0;
      for (int k = 0; k < N_LEVELS; k++) m = m + LW'(sv[k]);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         level        <= '0;
         down         <= 1'b1;
         sensor_fault <= 1'b0;
         fault_sticky <= 1'b0;
      end else if (!valid) begin
         sensor_fault <= 1'b1;
         fault_sticky <= 1'b1;
      end else begin
         sensor_fault <= 1'b0;
         if (m > level) begin
            level <= level + 1'b1;
            down  <= 1'b0;
         end else if (m < level) begin
            level <= level - 1'b1;
            down  <= 1'b1;
         end
      end
   end
   for (genvar i = 0; i < N_LEVELS; i++) begin : g_fr
      assign fr[i] = (int'(level) + i) < N_LEVELS;
   end
   assign dfr = (level == '0) | (down & (level != LW'(N_LEVELS)));
endmodule
